// File: rtl/recon_ctrl_pkg.sv
// Shared types and latency constants for the modulo-ADC reconstruction controller.
// fill_latency() is also used to size the core's adc_out pipe.
package recon_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int FIRST_TWO_DELAY = 16;
    localparam int STAGE_DELAY     = 44;
    localparam int CONV_DELAY      = 3;

    // Order 0 runs the core's default branch, which behaves like order 1.
    function automatic logic [31:0] fill_latency(input logic [1:0] n,
                                                 input int firstTwo = FIRST_TWO_DELAY,
                                                 input int stage    = STAGE_DELAY,
                                                 input int conv     = CONV_DELAY);
        logic [31:0] nEff;
        nEff = (n == 2'd0) ? 32'd1 : {30'd0, n};
        return unsigned'(firstTwo) + unsigned'(stage) * nEff + unsigned'(conv);
    endfunction

endpackage

// File: rtl/sample_tick_divider.sv
// Sample-rate strobe generator: one-clock tick every div_ratio clocks while run is high.
// div_ratio is captured only at wrap so a mid-period change lands on the next period.
module sample_tick_divider #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] div_ratio,
    output logic             tick
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic             everyClock;
    logic             wrap;

    assign everyClock = (ratio_q <= CNT_W'(1));
    assign wrap       = everyClock || (count_q == ratio_q - CNT_W'(1));
    assign tick       = run && wrap;

    // While stopped the ratio tracks the input so the first period uses the current setting.
    always_comb begin
        count_d = count_q;
        ratio_d = ratio_q;
        if (!run || wrap) begin
            count_d = '0;
            ratio_d = div_ratio;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ratio_q <= '0;
        end else begin
            count_q <= count_d;
            ratio_q <= ratio_d;
        end
    end

endmodule

// File: rtl/recon_order_sequencer.sv
// Sequencer for the reconstruction core: sample strobe, start/order control and
// safe order changes via pipeline flush followed by an order-dependent refill wait.
module recon_order_sequencer #(
    parameter int         CNT_W           = 16,
    parameter int         FIRST_TWO_DELAY = recon_ctrl_pkg::FIRST_TWO_DELAY,
    parameter int         STAGE_DELAY     = recon_ctrl_pkg::STAGE_DELAY,
    parameter int         CONV_DELAY      = recon_ctrl_pkg::CONV_DELAY,
    parameter int         FLUSH_CYCLES    = 4,
    parameter logic [1:0] DEFAULT_N       = 2'd2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic [1:0]       cfg_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             core_clk_en,
    output logic             core_start,
    output logic [1:0]       core_n,
    output logic             core_reset,
    output logic             out_gate,
    output logic [1:0]       state_o
);

    import recon_ctrl_pkg::*;

    state_t           state_q, state_d;
    logic [1:0]       coreN_q, coreN_d;
    logic [CNT_W-1:0] fillCnt_q, fillCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
    logic [CNT_W-1:0] fillLat;
    logic             divRun;
    logic             tick;
    logic             cfgAccept;

    assign fillLat = CNT_W'(fill_latency(coreN_q, FIRST_TWO_DELAY, STAGE_DELAY, CONV_DELAY));
    assign divRun  = (state_q == ST_FILL) || (state_q == ST_RUN);

    sample_tick_divider #(.CNT_W(CNT_W)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .run       (divRun),
        .div_ratio (div_ratio),
        .tick      (tick)
    );

    assign cfg_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign cfgAccept   = cfg_valid && cfg_ready;
    assign core_clk_en = tick;
    assign core_start  = divRun;
    assign core_reset  = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
    assign out_gate    = (state_q == ST_RUN);
    assign core_n      = coreN_q;
    assign state_o     = state_q;

    always_comb begin
        state_d    = state_q;
        coreN_d    = coreN_q;
        fillCnt_d  = fillCnt_q;
        flushCnt_d = flushCnt_q;

        if (cfgAccept) begin
            coreN_d = cfg_n;
        end

        case (state_q)
            ST_IDLE: begin
                flushCnt_d = '0;
                if (enable) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flushCnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d    = ST_FILL;
                    flushCnt_d = '0;
                    fillCnt_d  = '0;
                end else begin
                    flushCnt_d = flushCnt_q + CNT_W'(1);
                end
            end
            ST_FILL: begin
                if (tick) begin
                    if (fillCnt_q == fillLat - CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                    fillCnt_d = fillCnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (cfgAccept && (cfg_n != coreN_q)) begin
                    state_d    = ST_FLUSH;
                    flushCnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping enable wins over every transition, but an accepted cfg still lands.
        if (!enable) begin
            state_d    = ST_IDLE;
            flushCnt_d = '0;
            fillCnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            coreN_q    <= DEFAULT_N;
            fillCnt_q  <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            coreN_q    <= coreN_d;
            fillCnt_q  <= fillCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

endmodule
